// File: rtl/router_pkt_tx.sv
// router_pkt_tx: buffers one packet payload from a byte source, then drives
// header, payload and parity bytes onto a router bus that may stall via busy.
//
// Handshakes:
//   source side : a byte transfers on every rising edge where src_valid and
//                 src_ready are both 1. src_ready is high only while loading.
//   bus side    : the byte on data_out is consumed on every rising edge where
//                 busy is 0. While busy is 1, data_out and pkt_valid hold.
//                 pkt_valid qualifies the header and payload bytes only.
//                 The parity byte is always driven with pkt_valid low.
module router_pkt_tx #(
   parameter int MAX_LEN = 63
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       start,
   input  logic [1:0] dest_addr,
   input  logic [5:0] payload_len,
   input  logic       inject_err,
   input  logic [7:0] src_data,
   input  logic       src_valid,
   output logic       src_ready,
   input  logic       busy,
   output logic [7:0] data_out,
   output logic       pkt_valid,
   output logic       tx_busy,
   output logic       tx_done,
   output logic       err,
   output logic [2:0] dbg_state_o
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_LOAD    = 3'd1,
      S_HEADER  = 3'd2,
      S_PAYLOAD = 3'd3,
      S_PARITY  = 3'd4,
      S_DONE    = 3'd5
   } state_t;

   localparam logic [6:0] MAX_LEN_W = MAX_LEN[6:0];

   state_t     state_q, state_d;
   logic [1:0] addr_q, addr_d;
   logic [5:0] len_q, len_d;
   logic       inj_q, inj_d;
   logic [5:0] wr_ptr_q, wr_ptr_d;
   logic [5:0] rd_ptr_q, rd_ptr_d;
   logic [7:0] parity_q, parity_d;
   logic [7:0] data_out_q, data_out_d;
   logic       pkt_valid_q, pkt_valid_d;
   logic       tx_done_q, tx_done_d;
   logic       err_q, err_d;

   // Payload storage; contents are only meaningful for the packet in flight.
   logic [7:0] buf_q [MAX_LEN];

   logic       req_ok;
   logic       load_fire;
   logic       last_byte;
   logic [7:0] header_in;
   logic [7:0] header_q;

   // A request is usable only with a real destination and a length that fits.
   assign req_ok    = (dest_addr != 2'b11) && (payload_len != 6'd0) &&
                      ({1'b0, payload_len} <= MAX_LEN_W);
   assign header_in = {payload_len, dest_addr};
   assign header_q  = {len_q, addr_q};
   assign load_fire = (state_q == S_LOAD) && src_valid;
   assign last_byte = load_fire && (wr_ptr_q == (len_q - 6'd1));

   assign src_ready   = (state_q == S_LOAD);
   assign tx_busy     = (state_q != S_IDLE);
   assign data_out    = data_out_q;
   assign pkt_valid   = pkt_valid_q;
   assign tx_done     = tx_done_q;
   assign err         = err_q;
   assign dbg_state_o = state_q;

   // State register.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; bus states advance only on edges without a stall.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:    if (start && req_ok) state_d = S_LOAD;
         S_LOAD:    if (last_byte) state_d = S_HEADER;
         S_HEADER:  if (!busy) state_d = S_PAYLOAD;
         S_PAYLOAD: if (!busy && (rd_ptr_q == len_q)) state_d = S_PARITY;
         S_PARITY:  if (!busy) state_d = S_DONE;
         S_DONE:    state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase
   end

   // Output and datapath next values; everything holds unless a step fires.
   always_comb begin
      addr_d      = addr_q;
      len_d       = len_q;
      inj_d       = inj_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      parity_d    = parity_q;
      data_out_d  = data_out_q;
      pkt_valid_d = pkt_valid_q;
      tx_done_d   = 1'b0;
      err_d       = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               if (req_ok) begin
                  addr_d   = dest_addr;
                  len_d    = payload_len;
                  inj_d    = inject_err;
                  parity_d = header_in;
                  wr_ptr_d = 6'd0;
                  rd_ptr_d = 6'd0;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         S_LOAD: begin
            if (src_valid) begin
               parity_d = parity_q ^ src_data;
               wr_ptr_d = wr_ptr_q + 6'd1;
               // Header goes out on the same edge that takes the last byte.
               if (last_byte) begin
                  data_out_d  = header_q;
                  pkt_valid_d = 1'b1;
               end
            end
         end
         S_HEADER: begin
            if (!busy) begin
               data_out_d = buf_q[0];
               rd_ptr_d   = 6'd1;
            end
         end
         S_PAYLOAD: begin
            if (!busy) begin
               if (rd_ptr_q < len_q) begin
                  data_out_d = buf_q[rd_ptr_q];
                  rd_ptr_d   = rd_ptr_q + 6'd1;
               end else begin
                  data_out_d  = parity_q ^ {8{inj_q}};
                  pkt_valid_d = 1'b0;
               end
            end
         end
         S_PARITY: begin
            if (!busy) begin
               data_out_d = 8'h00;
               tx_done_d  = 1'b1;
            end
         end
         S_DONE: begin
            tx_done_d = 1'b0;
         end
         default: begin
            data_out_d  = 8'h00;
            pkt_valid_d = 1'b0;
         end
      endcase
   end

   // Datapath registers; reset abandons any packet in progress.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         addr_q      <= 2'd0;
         len_q       <= 6'd0;
         inj_q       <= 1'b0;
         wr_ptr_q    <= 6'd0;
         rd_ptr_q    <= 6'd0;
         parity_q    <= 8'h00;
         data_out_q  <= 8'h00;
         pkt_valid_q <= 1'b0;
         tx_done_q   <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         addr_q      <= addr_d;
         len_q       <= len_d;
         inj_q       <= inj_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         parity_q    <= parity_d;
         data_out_q  <= data_out_d;
         pkt_valid_q <= pkt_valid_d;
         tx_done_q   <= tx_done_d;
         err_q       <= err_d;
      end
   end

   // Payload buffer write; no reset needed since it is rewritten per packet.
   always_ff @(posedge clk) begin
      if (resetn && load_fire) begin
         buf_q[wr_ptr_q] <= src_data;
      end
   end

endmodule
